gt_wb_buffer: RTL and testbench
===============================

GT_WB_BUFFER -- requirements
Module: gt_wb_buffer

Interface
REQ-001 DEPTH, 4, number of buffered evicted lines; power of two, >= 2.
REQ-002 LINE_W, 256, line data width in bits (32-byte line).
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 evictValid  input  1  victim stage offers an evicted line this cycle.
REQ-006 evictAddr  input  32  byte address of evicted line; bits [4:0] ignored.
REQ-007 evictData  input  LINE_W  evicted line contents.
REQ-008 evictReady  output  1  buffer accepts offered line this cycle.
REQ-009 memReq  output  1  memory write request.
REQ-010 memAddr  output  32  line address being written; bits [4:0] always 0.
REQ-011 memData  output  LINE_W  line data being written.
REQ-012 memAck  input  1  one-cycle pulse: memory accepted current write.
REQ-013 lookupAddr  input  32  byte address probed by the victim stage on a miss.
REQ-014 lookupHit  output  1  probed line is resident in the buffer.
REQ-015 lookupData  output  LINE_W  resident line contents; 0 on miss.
REQ-016 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {valid, tag = addr[31:5] (27 bits), data}, with head/tail pointers wrapping DEPTH-1 -> 0.
REQ-018 Coalesce match SHALL be: evictValid, and evictAddr[31:5] equals the tag of a valid entry that is not the head while the FSM is in REQ.
REQ-019 evictReady SHALL be combinational: (count < DEPTH) OR coalesce match.
REQ-020 Push on coalesce match SHALL overwrite that entry's data in place; count and tail are unchanged.
REQ-021 Push without coalesce match SHALL write at tail, advance tail, and increment count.
REQ-022 A line matching the in-flight head SHALL be appended as a new entry; in-flight data stays frozen.
REQ-023 Drain FSM states SHALL be IDLE and REQ; memReq = (state == REQ).
REQ-024 IDLE -> REQ at the edge where count > 0; push at edge N gives memReq high from edge N+1.
REQ-025 In REQ, memAddr = {head tag, 5'b0} and memData = head data; both SHALL be stable until memAck.
REQ-026 memAck in REQ SHALL pop the head (clear valid, advance head, decrement count); stay in REQ if entries remain after the pop, else go IDLE.
REQ-027 memAck in IDLE SHALL be ignored.
REQ-028 Simultaneous push and pop: count net unchanged; a full buffer SHALL NOT accept a non-coalescing push in the pop cycle (no bypass).
REQ-029 lookupHit/lookupData SHALL be combinational over all valid entries; if several match, return the youngest.
REQ-030 evictValid with evictReady low SHALL leave state unchanged; the source holds the line.

Reset
REQ-031 RST_N low SHALL immediately clear all valid bits, zero head/tail/count, force IDLE, drive memReq=0, memAddr=0, memData=0, lookupHit=0, lookupData=0.
REQ-032 Reset mid-transfer SHALL abandon the in-flight line; evictReady SHALL be 1 at the first edge after RST_N rises.

Structure
REQ-033 Shared package gt_wb_pkg SHALL hold TAG_W=27, OFFSET_W=5, LINE_W default, and the drain-state enum.
REQ-034 Tag storage and match logic SHALL be one sub-module, gt_wb_cam (tags, valids, per-entry match vector); FIFO control and FSM stay in gt_wb_buffer.

Verification
REQ-035 Push addr 0x00000040, data A -> memReq high next cycle with memAddr 0x00000040, memData A; memAck -> count 0, memReq low.
REQ-036 Four pushes, no memAck -> count 4, evictReady 0; fifth push of a new addr is stalled and unchanged until one memAck.
REQ-037 Push 0x100 (head, in flight), then 0x200 twice with data B then C -> count 2; lookup 0x200 returns C; 0x100 drains first.
REQ-038 Push 0x100 data A in flight, push 0x100 data D -> new entry (count 2); memData stays A until memAck, then D is written.
REQ-039 Full buffer, push plus memAck on same edge -> pop only, count 3, pushed line still pending.
REQ-040 Assert RST_N low during REQ -> memReq 0 at once, count 0, lookupHit 0; after release, a push drains normally.

Source files
------------

// File: rtl/gt_wb_pkg.sv
// rtl/gt_wb_pkg.sv - shared constants and drain-state type for the write-back buffer
//
// TAG_W          : line tag width (address bits [31:5])
// OFFSET_W       : byte offset width within a 32-byte line
// DEFAULT_LINE_W : default line data width in bits
// drain_state_e  : IDLE / REQ states of the memory drain FSM
package gt_wb_pkg;
  localparam int TAG_W          = 27;
  localparam int OFFSET_W       = 5;
  localparam int DEFAULT_LINE_W = 256;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_e;
endpackage

// File: rtl/gt_wb_cam.sv
// rtl/gt_wb_cam.sv - tag/valid storage with per-entry match vectors for the write-back buffer
//
// CLK, RST_N    : clock, asynchronous active-low reset (clears all valids)
// alloc         : write alloc_tag into entry alloc_idx and mark it valid
// free          : clear the valid bit of entry free_idx
// evict_tag     : tag compared against every valid entry -> evict_match
// lookup_tag    : tag compared against every valid entry -> lookup_match
// rd_idx/rd_tag : read port for the tag of one entry (the drain head)
module gt_wb_cam
  import gt_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     alloc,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic                     free,
  input  logic [$clog2(DEPTH)-1:0] free_idx,
  input  logic [TAG_W-1:0]         evict_tag,
  input  logic [TAG_W-1:0]         lookup_tag,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [DEPTH-1:0]         evict_match,
  output logic [DEPTH-1:0]         lookup_match
);

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][TAG_W-1:0] tags;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= '0;
      tags  <= '0;
    end else begin
      // Allocation and free never target the same entry in one cycle:
      // tail == head only when empty (no free) or full (no alloc).
      if (free) begin
        valid[free_idx] <= 1'b0;
      end
      if (alloc) begin
        valid[alloc_idx] <= 1'b1;
        tags[alloc_idx]  <= alloc_tag;
      end
    end
  end

  always_comb begin
    evict_match  = '0;
    lookup_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      evict_match[i]  = valid[i] && (tags[i] == evict_tag);
      lookup_match[i] = valid[i] && (tags[i] == lookup_tag);
    end
  end

  assign rd_tag = tags[rd_idx];

endmodule

// File: rtl/gt_wb_buffer.sv
// rtl/gt_wb_buffer.sv - circular write-back buffer with coalescing, lookup and memory drain FSM
//
// CLK, RST_N                         : clock, asynchronous active-low reset
// evictValid/evictAddr/evictData     : evicted line offered by the victim stage
// evictReady                         : line accepted this cycle (space free or coalesce hit)
// memReq/memAddr/memData/memAck      : one-line-at-a-time write to memory, head first
// lookupAddr/lookupHit/lookupData    : combinational probe of resident lines (youngest wins)
// count                              : number of valid entries
module gt_wb_buffer
  import gt_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = DEFAULT_LINE_W
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   evictValid,
  input  logic [31:0]            evictAddr,
  input  logic [LINE_W-1:0]      evictData,
  output logic                   evictReady,
  output logic                   memReq,
  output logic [31:0]            memAddr,
  output logic [LINE_W-1:0]      memData,
  input  logic                   memAck,
  input  logic [31:0]            lookupAddr,
  output logic                   lookupHit,
  output logic [LINE_W-1:0]      lookupData,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_state_e      state, state_nxt;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [LINE_W-1:0] data_mem [DEPTH];

  logic [DEPTH-1:0]  evict_match, lookup_match, head_oh, coal_vec;
  logic [TAG_W-1:0]  head_tag;
  logic [PTR_W-1:0]  coal_idx, push_idx, lookup_sel;
  logic              coalesce, push, push_new, pop, lookup_any;
  logic              unused_offset_bits;

  assign unused_offset_bits = ^{evictAddr[OFFSET_W-1:0], lookupAddr[OFFSET_W-1:0]};

  gt_wb_cam #(.DEPTH(DEPTH)) u_cam (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .alloc        (push_new),
    .alloc_idx    (tail),
    .alloc_tag    (evictAddr[31:OFFSET_W]),
    .free         (pop),
    .free_idx     (head),
    .evict_tag    (evictAddr[31:OFFSET_W]),
    .lookup_tag   (lookupAddr[31:OFFSET_W]),
    .rd_idx       (head),
    .rd_tag       (head_tag),
    .evict_match  (evict_match),
    .lookup_match (lookup_match)
  );

  // The in-flight head is excluded from coalescing so memData stays frozen
  // until memAck; a line matching it is appended as a fresh entry instead.
  assign head_oh  = DEPTH'(1) << head;
  assign coal_vec = evict_match & ~((state == DRAIN_REQ) ? head_oh : '0);
  assign coalesce = evictValid && (|coal_vec);

  always_comb begin
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (coal_vec[i]) begin
        coal_idx = PTR_W'(i);
      end
    end
  end

  // No pop-cycle bypass: a full buffer refuses new lines even while popping.
  assign evictReady = (cnt_q < CNT_W'(DEPTH)) || coalesce;
  assign push       = evictValid && evictReady;
  assign push_new   = push && !coalesce;
  assign pop        = (state == DRAIN_REQ) && memAck;
  assign push_idx   = coalesce ? coal_idx : tail;

  always_comb begin
    case ({push_new, pop})
      2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
      2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_new) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      cnt_q <= cnt_nxt;
    end
  end

  // Line data needs no reset: every output path is gated by a valid bit or the FSM state.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[push_idx] <= evictData;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= DRAIN_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN_IDLE: if (cnt_q != '0) state_nxt = DRAIN_REQ;
      DRAIN_REQ:  if (memAck) state_nxt = (cnt_nxt != '0) ? DRAIN_REQ : DRAIN_IDLE;
      default:    state_nxt = DRAIN_IDLE;
    endcase
  end

  assign memReq  = (state == DRAIN_REQ);
  assign memAddr = memReq ? {head_tag, {OFFSET_W{1'b0}}} : '0;
  assign memData = memReq ? data_mem[head] : '0;
  assign count   = cnt_q;

  // Walk from head (oldest) towards tail so the last hit is the youngest copy.
  always_comb begin
    lookup_any = 1'b0;
    lookup_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lookup_match[head + PTR_W'(k)]) begin
        lookup_any = 1'b1;
        lookup_sel = head + PTR_W'(k);
      end
    end
  end

  assign lookupHit  = lookup_any;
  assign lookupData = lookup_any ? data_mem[lookup_sel] : '0;

endmodule

// File: tb/tb_gt_wb_buffer.sv
// tb/tb_gt_wb_buffer.sv - self-checking bench for gt_wb_buffer
module tb_gt_wb_buffer;

  localparam int DEPTH  = 4;
  localparam int LINE_W = 256;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              evictValid;
  logic [31:0]       evictAddr;
  logic [LINE_W-1:0] evictData;
  logic              evictReady;
  logic              memReq;
  logic [31:0]       memAddr;
  logic [LINE_W-1:0] memData;
  logic              memAck;
  logic [31:0]       lookupAddr;
  logic              lookupHit;
  logic [LINE_W-1:0] lookupData;
  logic [2:0]        count;

  int tests = 0;
  int fails = 0;

  gt_wb_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .evictValid (evictValid),
    .evictAddr  (evictAddr),
    .evictData  (evictData),
    .evictReady (evictReady),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memData    (memData),
    .memAck     (memAck),
    .lookupAddr (lookupAddr),
    .lookupHit  (lookupHit),
    .lookupData (lookupData),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ev;
    logic [31:0] addr;
    logic [31:0] seed;
    logic        ack;
    logic        exp_ready;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mseed;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [LINE_W-1:0] rep(input logic [31:0] s);
    return {8{s}};
  endfunction

  function automatic vec_t mk(input logic ev, input logic [31:0] addr, input logic [31:0] seed,
                              input logic ack, input logic rdy, input logic req,
                              input logic [31:0] maddr, input logic [31:0] mseed,
                              input logic [2:0] cnt);
    vec_t v;
    v.ev = ev; v.addr = addr; v.seed = seed; v.ack = ack;
    v.exp_ready = rdy; v.exp_req = req; v.exp_maddr = maddr; v.exp_mseed = mseed;
    v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] addr, input logic [LINE_W-1:0] data,
                       input logic ack, input logic [31:0] laddr);
    evictValid = ev;
    evictAddr  = addr;
    evictData  = data;
    memAck     = ack;
    lookupAddr = laddr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, '0, 1'b0, 32'h0);
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  // Behavioural reference: oldest line at index 0 of the queues.
  bit [26:0]       mq_tag[$];
  bit [LINE_W-1:0] mq_dat[$];
  bit              m_req;

  localparam logic [31:0] SA = 32'hA1A1_A1A1;
  localparam logic [31:0] S0 = 32'h1111_0000;
  localparam logic [31:0] S1 = 32'h2222_0001;
  localparam logic [31:0] S2 = 32'h3333_0002;
  localparam logic [31:0] S3 = 32'h4444_0003;
  localparam logic [31:0] S4 = 32'h5555_0004;

  initial begin
    tbl[0]  = mk(1, 32'h0000_0040, SA, 0, 1, 0, 32'h0,         32'h0, 3'd1);
    tbl[1]  = mk(0, 32'h0,         0,  0, 1, 0, 32'h0,         32'h0, 3'd1);
    tbl[2]  = mk(0, 32'h0,         0,  1, 1, 1, 32'h0000_0040, SA,    3'd0);
    tbl[3]  = mk(0, 32'h0,         0,  0, 1, 0, 32'h0,         32'h0, 3'd0);
    tbl[4]  = mk(1, 32'h0000_1000, S0, 0, 1, 0, 32'h0,         32'h0, 3'd1);
    tbl[5]  = mk(1, 32'h0000_2000, S1, 0, 1, 0, 32'h0,         32'h0, 3'd2);
    tbl[6]  = mk(1, 32'h0000_3000, S2, 0, 1, 1, 32'h0000_1000, S0,    3'd3);
    tbl[7]  = mk(1, 32'h0000_4000, S3, 0, 1, 1, 32'h0000_1000, S0,    3'd4);
    tbl[8]  = mk(1, 32'h0000_5013, S4, 0, 0, 1, 32'h0000_1000, S0,    3'd4);
    tbl[9]  = mk(1, 32'h0000_501F, S4, 1, 0, 1, 32'h0000_1000, S0,    3'd3);
    tbl[10] = mk(1, 32'h0000_501F, S4, 0, 1, 1, 32'h0000_2000, S1,    3'd4);
    tbl[11] = mk(0, 32'h0,         0,  1, 0, 1, 32'h0000_2000, S1,    3'd3);
    tbl[12] = mk(0, 32'h0,         0,  1, 1, 1, 32'h0000_3000, S2,    3'd2);
    tbl[13] = mk(0, 32'h0,         0,  1, 1, 1, 32'h0000_4000, S3,    3'd1);
    tbl[14] = mk(0, 32'h0,         0,  1, 1, 1, 32'h0000_5000, S4,    3'd0);
    tbl[15] = mk(0, 32'h0,         0,  0, 1, 0, 32'h0,         32'h0, 3'd0);

    // Reset state, observed while RST_N is still low.
    drive(1'b0, 32'h0, '0, 1'b0, 32'h0);
    RST_N = 1'b0;
    #2;
    chk("rst_memReq", memReq, 0);
    chk("rst_count", count, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memData", memData, 0);
    chk("rst_lookupHit", lookupHit, 0);
    chk("rst_lookupData", lookupData, 0);
    chk("rst_evictReady", evictReady, 1);
    apply_reset();

    // Directed table: single drain, fill/stall, push-during-pop on full buffer.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ev, tbl[i].addr, rep(tbl[i].seed), tbl[i].ack, 32'h0000_1000);
      #1;
      chk($sformatf("tbl%0d_ready", i), evictReady, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_req", i), memReq, tbl[i].exp_req);
      chk($sformatf("tbl%0d_maddr", i), memAddr, tbl[i].exp_maddr);
      chk($sformatf("tbl%0d_mdata", i), memData, rep(tbl[i].exp_mseed));
      tick();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
    end

    // Coalesce into a non-head entry while the head is in flight.
    apply_reset();
    drive(1, 32'h100, rep(32'hAAAA_0100), 0, 32'h200);
    tick();
    drive(0, 32'h0, '0, 0, 32'h200);
    tick();
    drive(1, 32'h200, rep(32'hBBBB_0200), 0, 32'h200);
    tick();
    chk("coal_cnt_b", count, 2);
    drive(1, 32'h200, rep(32'hCCCC_0200), 0, 32'h200);
    #1;
    chk("coal_ready", evictReady, 1);
    tick();
    chk("coal_cnt_c", count, 2);
    chk("coal_lk_hit", lookupHit, 1);
    chk("coal_lk_data", lookupData, rep(32'hCCCC_0200));
    chk("coal_head_addr", memAddr, 32'h100);
    chk("coal_head_data", memData, rep(32'hAAAA_0100));
    drive(0, 32'h0, '0, 1, 32'h200);
    tick();
    chk("coal_next_addr", memAddr, 32'h200);
    chk("coal_next_data", memData, rep(32'hCCCC_0200));
    chk("coal_next_cnt", count, 1);
    drive(0, 32'h0, '0, 1, 32'h200);
    tick();
    chk("coal_empty_cnt", count, 0);

    // Same line as the in-flight head: appended, head data frozen.
    apply_reset();
    drive(1, 32'h100, rep(32'hAAAA_AAAA), 0, 32'h100);
    tick();
    drive(0, 32'h0, '0, 0, 32'h100);
    tick();
    drive(1, 32'h100, rep(32'hDDDD_DDDD), 0, 32'h100);
    tick();
    chk("inflt_cnt", count, 2);
    chk("inflt_frozen", memData, rep(32'hAAAA_AAAA));
    chk("inflt_lk_young", lookupData, rep(32'hDDDD_DDDD));
    drive(0, 32'h0, '0, 0, 32'h100);
    tick();
    chk("inflt_still", memData, rep(32'hAAAA_AAAA));
    drive(0, 32'h0, '0, 1, 32'h100);
    tick();
    chk("inflt_d_data", memData, rep(32'hDDDD_DDDD));
    chk("inflt_d_addr", memAddr, 32'h100);
    chk("inflt_d_cnt", count, 1);
    drive(0, 32'h0, '0, 1, 32'h100);
    tick();
    chk("inflt_done_cnt", count, 0);
    chk("inflt_done_req", memReq, 0);

    // Reset in the middle of a transfer.
    apply_reset();
    drive(1, 32'h80, rep(32'hEEEE_0080), 0, 32'h80);
    tick();
    drive(0, 32'h0, '0, 0, 32'h80);
    tick();
    chk("mid_req_up", memReq, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_req", memReq, 0);
    chk("mid_cnt", count, 0);
    chk("mid_hit", lookupHit, 0);
    chk("mid_addr", memAddr, 0);
    tick();
    RST_N = 1'b1;
    #1;
    chk("mid_ready", evictReady, 1);
    drive(1, 32'h80, rep(32'hFFFF_0080), 0, 32'h80);
    tick();
    drive(0, 32'h0, '0, 0, 32'h80);
    tick();
    chk("mid_redrain_req", memReq, 1);
    chk("mid_redrain_data", memData, rep(32'hFFFF_0080));
    drive(0, 32'h0, '0, 1, 32'h80);
    tick();
    chk("mid_redrain_cnt", count, 0);

    // Randomized traffic against the queue model.
    apply_reset();
    mq_tag.delete();
    mq_dat.delete();
    m_req = 0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0]       a, la;
      logic [LINE_W-1:0] d;
      logic              ev, ack, e_ready, e_hit, coal, pop;
      logic [LINE_W-1:0] e_ldat;
      int                ci, sz;
      ev  = ($urandom_range(0, 1) == 1);
      a   = 32'h0001_0000 + 32'h20 * $urandom_range(0, 5) + 32'($urandom_range(0, 31));
      la  = 32'h0001_0000 + 32'h20 * $urandom_range(0, 6);
      d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ack = ($urandom_range(0, 2) == 0);
      drive(ev, a, d, ack, la);
      #1;
      ci = -1;
      for (int j = (m_req ? 1 : 0); j < mq_tag.size(); j++)
        if (mq_tag[j] == a[31:5]) ci = j;
      coal    = ev && (ci >= 0);
      e_ready = (mq_tag.size() < DEPTH) || coal;
      e_hit   = 0;
      e_ldat  = '0;
      for (int j = 0; j < mq_tag.size(); j++)
        if (mq_tag[j] == la[31:5]) begin e_hit = 1; e_ldat = mq_dat[j]; end
      chk("rnd_ready", evictReady, e_ready);
      chk("rnd_req", memReq, m_req);
      chk("rnd_maddr", memAddr, m_req ? {mq_tag[0], 5'b0} : 32'h0);
      chk("rnd_mdata", memData, m_req ? mq_dat[0] : '0);
      chk("rnd_count", count, mq_tag.size());
      chk("rnd_lkhit", lookupHit, e_hit);
      chk("rnd_lkdata", lookupData, e_ldat);
      tick();
      sz  = mq_tag.size();
      pop = m_req && ack;
      if (ev && e_ready) begin
        if (coal) mq_dat[ci] = d;
        else begin mq_tag.push_back(a[31:5]); mq_dat.push_back(d); end
      end
      if (pop) begin
        void'(mq_tag.pop_front());
        void'(mq_dat.pop_front());
      end
      if (m_req) m_req = pop ? (mq_tag.size() > 0) : 1'b1;
      else       m_req = (sz > 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
